// File: rtl/arith_display_pkg.sv
// arith_display_pkg: shared types and constants for the add/sub display controller
package arith_display_pkg;
    typedef enum logic [1:0] {IDLE, COMPUTE, CONVERT, DONE} state_t;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam int         BCD_TEN   = 10;
    localparam logic       OP_ADD    = 1'b0;
    localparam logic       OP_SUB    = 1'b1;
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: 4-bit hex to active-low seven-segment pattern {g,f,e,d,c,b,a}
module seg7_decode (
    input  logic [3:0] i_hex,
    output logic [6:0] o_seg
);
    always_comb begin
        o_seg = 7'h7F;
        case (i_hex)
            4'h0: o_seg = 7'h40;
            4'h1: o_seg = 7'h79;
            4'h2: o_seg = 7'h24;
            4'h3: o_seg = 7'h30;
            4'h4: o_seg = 7'h19;
            4'h5: o_seg = 7'h12;
            4'h6: o_seg = 7'h02;
            4'h7: o_seg = 7'h78;
            4'h8: o_seg = 7'h00;
            4'h9: o_seg = 7'h10;
            4'hA: o_seg = 7'h08;
            4'hB: o_seg = 7'h03;
            4'hC: o_seg = 7'h46;
            4'hD: o_seg = 7'h21;
            4'hE: o_seg = 7'h06;
            4'hF: o_seg = 7'h0E;
            default: o_seg = 7'h7F;
        endcase
    end
endmodule

// File: rtl/arith_display_ctrl.sv
// arith_display_ctrl: add/sub sequencer with iterative BCD conversion and 4-digit scanned display
// Define LEADING_ZERO_BLANK_EN to blank the tens digit when it is zero.
module arith_display_ctrl
    import arith_display_pkg::*;
#(
    parameter int W        = 4,
    parameter int SCAN_DIV = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] inA,
    input  logic [W-1:0] inB,
    input  logic         op,
    output logic         busy,
    output logic         done,
    output logic         signal,
    output logic [1:0]   tens,
    output logic [3:0]   ones,
    output logic [3:0]   an,
    output logic [6:0]   seg
);
    localparam int             SW        = $clog2(SCAN_DIV + 1);
    localparam logic [SW-1:0]  SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [W:0]     TEN       = (W+1)'(BCD_TEN);

    state_t        r_state;
    logic [W-1:0]  r_a, r_b;
    logic          r_op, r_neg;
    logic [W:0]    r_mag;
    logic [1:0]    r_tcnt;
    logic [SW-1:0] r_scan;
    logic [1:0]    r_digit;
    logic [3:0]    w_hex;
    logic [6:0]    w_seg;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= OP_ADD;
            r_neg   <= 1'b0;
            r_mag   <= '0;
            r_tcnt  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            signal  <= 1'b0;
            tens    <= '0;
            ones    <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: if (start) begin
                    r_a     <= inA;
                    r_b     <= inB;
                    r_op    <= op;
                    busy    <= 1'b1;
                    r_state <= COMPUTE;
                end
                COMPUTE: begin
                    r_mag   <= (r_op == OP_SUB) ? ((r_a >= r_b) ? {1'b0, r_a - r_b} : {1'b0, r_b - r_a})
                                                : {1'b0, r_a} + {1'b0, r_b};
                    r_neg   <= (r_op == OP_SUB) && (r_a < r_b);
                    r_tcnt  <= '0;
                    r_state <= CONVERT;
                end
                CONVERT: if (r_mag >= TEN) begin
                    r_mag  <= r_mag - TEN;
                    r_tcnt <= r_tcnt + 2'd1;
                end else begin
                    r_state <= DONE;
                end
                DONE: begin
                    done    <= 1'b1;
                    tens    <= r_tcnt;
                    ones    <= r_mag[3:0];
                    signal  <= r_neg;
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Scan runs free of the FSM; an and seg both derive from r_digit so they switch together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_scan  <= '0;
            r_digit <= '0;
        end else if (r_scan == SCAN_LAST) begin
            r_scan  <= '0;
            r_digit <= r_digit + 2'd1;
        end else begin
            r_scan <= r_scan + 1'b1;
        end
    end

    assign an = ~(4'b0001 << r_digit);

    always_comb begin
        w_hex = (r_digit == 2'd0) ? 4'(r_a) :
                (r_digit == 2'd1) ? 4'(r_b) :
                (r_digit == 2'd2) ? ones : {2'b00, tens};
    end

    seg7_decode u_dec (
        .i_hex(w_hex),
        .o_seg(w_seg)
    );

`ifdef LEADING_ZERO_BLANK_EN
    assign seg = (r_digit == 2'd3 && tens == 2'd0) ? SEG_BLANK : w_seg;
`else
    assign seg = w_seg;
`endif
endmodule

// File: tb/tb_arith_display_ctrl.sv
// tb_arith_display_ctrl: directed self-checking bench for arith_display_ctrl
module tb_arith_display_ctrl;
    logic       clk = 1'b0, rst = 1'b1, start = 1'b0, op = 1'b0;
    logic [3:0] inA = '0, inB = '0;
    logic       busy, done, signal;
    logic [1:0] tens;
    logic [3:0] ones, an;
    logic [6:0] seg;
    int n_chk = 0, n_pass = 0;
    int lat, bc, nd;
    logic [3:0] e_an;
    logic [6:0] e_seg;

    always #5 clk = ~clk;

    arith_display_ctrl #(.W(4), .SCAN_DIV(4)) dut (
        .clk(clk), .rst(rst), .start(start), .inA(inA), .inB(inB), .op(op),
        .busy(busy), .done(done), .signal(signal), .tens(tens), .ones(ones),
        .an(an), .seg(seg)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] hex7(input logic [3:0] h);
        logic [6:0] t [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return t[h];
    endfunction

    // Pulse start for one edge, then return cycles-to-done and cycles busy was seen high.
    task automatic run(input logic [3:0] a, input logic [3:0] b, input logic o,
                       output int l, output int bcnt);
        inA = a; inB = b; op = o; start = 1'b1;
        tick;
        start = 1'b0;
        l = -1; bcnt = 0;
        for (int k = 1; k <= 20; k++) begin
            if (busy) bcnt++;
            tick;
            if (done) begin
                l = k;
                break;
            end
        end
    endtask

    initial begin
        // Reset state and display scan
        rst = 1'b1;
        tick;
        tick;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_signal", signal, 0);
        chk("rst_tens", tens, 0);
        chk("rst_ones", ones, 0);
        chk("rst_an", an, 4'b1110);
        rst = 1'b0;
        for (int i = 1; i < 20; i++) begin
            tick;
            e_an = ~(4'b0001 << ((i / 4) % 4));
            chk("scan_an", an, e_an);
`ifdef LEADING_ZERO_BLANK_EN
            e_seg = (e_an == 4'b0111) ? 7'h7F : 7'h40;
`else
            e_seg = 7'h40;
`endif
            chk("scan_seg_zero", seg, e_seg);
        end

        run(4'd7, 4'd8, 1'b0, lat, bc);
        chk("add15_lat", lat, 4);
        chk("add15_tens", tens, 1);
        chk("add15_ones", ones, 5);
        chk("add15_sign", signal, 0);
        chk("add15_busy_after", busy, 0);

        run(4'd3, 4'd9, 1'b1, lat, bc);
        chk("sub_neg_lat", lat, 3);
        chk("sub_neg_tens", tens, 0);
        chk("sub_neg_ones", ones, 6);
        chk("sub_neg_sign", signal, 1);

        run(4'd5, 4'd5, 1'b1, lat, bc);
        chk("sub_zero_lat", lat, 3);
        chk("sub_zero_sign", signal, 0);
        chk("sub_zero_ones", ones, 0);

        run(4'd10, 4'd0, 1'b0, lat, bc);
        chk("add10_lat", lat, 4);
        chk("add10_tens", tens, 1);
        chk("add10_ones", ones, 0);

        run(4'd15, 4'd15, 1'b0, lat, bc);
        chk("add30_lat", lat, 6);
        chk("add30_busy_cycles", bc, 6);
        chk("add30_tens", tens, 3);
        chk("add30_ones", ones, 0);

        // Display content: A=C, B=3, ones=5, tens=1
        run(4'd12, 4'd3, 1'b0, lat, bc);
        chk("add_c3_lat", lat, 4);
        for (int i = 0; i < 16; i++) begin
            tick;
            chk("disp_onehot", $countones(~an), 1);
            e_seg = (an == 4'b1110) ? hex7(4'hC) :
                    (an == 4'b1101) ? hex7(4'h3) :
                    (an == 4'b1011) ? hex7(4'h5) : hex7(4'h1);
            chk("disp_seg", seg, e_seg);
        end

        // start while busy is ignored
        inA = 4'd9; inB = 4'd2; op = 1'b1; start = 1'b1;
        tick;
        chk("ign_busy", busy, 1);
        inA = 4'd15; inB = 4'd15; op = 1'b0;
        tick;
        tick;
        start = 1'b0;
        nd = 0;
        for (int k = 0; k < 12; k++) begin
            tick;
            if (done) nd++;
        end
        chk("ign_done_count", nd, 1);
        chk("ign_tens", tens, 0);
        chk("ign_ones", ones, 7);
        chk("ign_sign", signal, 0);

        // Reset during CONVERT
        inA = 4'd15; inB = 4'd15; op = 1'b0; start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        tick;
        rst = 1'b1;
        tick;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_tens", tens, 0);
        chk("mid_rst_ones", ones, 0);
        chk("mid_rst_sign", signal, 0);
        chk("mid_rst_an", an, 4'b1110);
        rst = 1'b0;
        nd = 0;
        for (int k = 0; k < 10; k++) begin
            tick;
            if (done || busy) nd++;
        end
        chk("mid_rst_quiet", nd, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
